udp_rx_port_demux: RTL
======================

// Module: udp_rx_port_demux
// PURPOSE
// - Parametrised UDP receive back end. It sits after the UDP stack and steers each received datagram
//   (header + byte payload stream) to one of NUM_CH channels by destination-port match.
// - Datagrams that match no enabled channel are drained and dropped.
// - Generalises the single fixed-port receive path to N runtime-configurable ports, and adds a
//   header-length computation that saturates instead of wrapping.
// PARAMETERS
// - NUM_CH     4   number of output channels (1..8)
// - HDR_BYTES  8   bytes subtracted from s_udp_length to form m_payload_len
// - CNT_W      32  width of each statistics counter
// PORTS
// - logic_clk                 in   1          single clock; everything is synchronous to it
// - rst_n                     in   1          asynchronous, active-low reset
// - s_udp_hdr_valid           in   1          input header valid
// - s_udp_hdr_ready           out  1          input header ready
// - s_udp_ip_source_ip        in   32         source IP of the datagram
// - s_udp_dest_port           in   16         UDP destination port
// - s_udp_length              in   16         UDP length field (header + payload)
// - s_udp_payload_axis_tdata  in   8          input payload byte
// - s_udp_payload_axis_tvalid in   1          input payload valid
// - s_udp_payload_axis_tready out  1          input payload ready
// - s_udp_payload_axis_tlast  in   1          input payload last byte
// - s_udp_payload_axis_tuser  in   1          input payload error flag
// - cfg_port                  in   16*NUM_CH  listen port of channel i at [16i+15:16i]
// - cfg_en                    in   NUM_CH     per-channel enable
// - m_hdr_valid               out  NUM_CH     one-hot header valid
// - m_hdr_ready               in   NUM_CH     per-channel header ready
// - m_source_ip               out  32         latched source IP, shared by all channels
// - m_payload_len             out  16         latched payload length, shared by all channels
// - m_axis_tdata              out  8          payload byte, shared by all channels
// - m_axis_tvalid             out  NUM_CH     one-hot payload valid
// - m_axis_tready             in   NUM_CH     per-channel payload ready
// - m_axis_tlast              out  1          payload last, shared by all channels
// - m_axis_tuser              out  1          payload error flag, shared by all channels
// - drop_pulse                out  1          1-cycle pulse on the last byte of a dropped datagram
// - stat_rx_cnt               out  CNT_W*NUM_CH  per-channel accepted-datagram count
// - stat_drop_cnt             out  CNT_W      dropped-datagram count
// BEHAVIOUR
// - Reset: FSM goes to IDLE; every valid, drop_pulse, m_source_ip, m_payload_len and counter is 0.
//   A reset asserted mid-frame aborts the frame at once; any remaining input bytes are not drained.
// - FSM states IDLE, HDR, PAY, DROP.
//   - IDLE: s_udp_hdr_ready = 1. On the header handshake, latch the source IP and the computed length.
//     Match = lowest index i with cfg_en[i] && cfg_port[i] == s_udp_dest_port.
//     Match found -> HDR, with sel = i. No match -> DROP.
//   - HDR: m_hdr_valid[sel] = 1, registered, one cycle after the input handshake.
//     On m_hdr_ready[sel] -> PAY.
//   - PAY: combinational pass-through, zero latency.
//     m_axis_tvalid[sel] = s tvalid; s tready = m_axis_tready[sel]; tdata, tlast and tuser pass through.
//     On a tlast beat handshake -> IDLE.
//   - DROP: s tready = 1 and all m_axis_tvalid = 0. On a tlast beat, pulse drop_pulse -> IDLE.
//   - s_udp_hdr_ready = 0 in every state except IDLE.
// - Width/arithmetic:
//   - m_payload_len = s_udp_length - HDR_BYTES, saturating at 0 when s_udp_length < HDR_BYTES.
//   - cfg_port and cfg_en are sampled only at the IDLE header handshake.
//     Changing them mid-frame does not affect the frame in progress.
// - Boundary cases:
//   - Single-byte payload: tlast on the first beat returns to IDLE.
//   - Back-to-back datagrams: a new header is accepted in the cycle after the final tlast (1-cycle gap).
//   - Duplicate ports: the lowest index channel wins.
//   - All cfg_en = 0: every datagram is dropped.
//   - tuser is forwarded unchanged; the block never drops a frame because tuser is set.
// - Outputs not selected hold valid = 0. Shared data outputs may toggle freely.
// CONFIGURATION
// - UDP_RX_STATS_EN defined:
//   - stat_rx_cnt[i] increments on the tlast handshake of every datagram routed to channel i.
//   - stat_drop_cnt increments with drop_pulse.
//   - Counters wrap at 2^CNT_W and are cleared only by reset.
// - UDP_RX_STATS_EN undefined: stat ports remain and are driven constant 0, and no counter logic is built.
// TESTING
// - T1 Match: cfg_port0=1234, cfg_en=4'b0001; header port 1234, length 18, 10 bytes 0x00..0x09.
//   -> m_hdr_valid=0001 one cycle later, m_payload_len=10, bytes 0x00..0x09 on ch0, tlast on 0x09.
// - T2 Drop: header port 5555, no channel matches, 20-byte payload.
//   -> no m_* valid; s tready=1 throughout; drop_pulse on the 20th byte; stat_drop_cnt=1 (STATS_EN).
// - T3 Priority and backpressure: ch1 and ch2 both set to 2000; m_axis_tready[1] toggles 1010...
//   -> only ch1 is selected; no byte is lost or duplicated; throughput is 50%.
// - T4 Saturation: s_udp_length=5 with a 1-byte payload -> m_payload_len=0; the frame is delivered normally.
// - T5 Reset mid-frame: rst_n low after byte 3 of 10.
//   -> all outputs 0 and FSM in IDLE; the next header is accepted normally.
// - T6 Stats: route 3 frames to ch2 and 1 to ch0.
//   -> stat_rx_cnt = {0,3,0,1} with UDP_RX_STATS_EN; all 0 without it.

Source files
------------

// File: rtl/udp_rx_port_demux.sv
// ---------------------------------------------------------------------------
// udp_rx_port_demux
//
// UDP receive back end. It takes one datagram at a time from the UDP stack as
// a header followed by a byte payload stream. It steers the datagram to one of
// NUM_CH output channels by matching the destination port. A datagram that
// matches no enabled channel is drained from the input and dropped.
//
// Optional feature macro: UDP_RX_STATS_EN
//   defined   -> per-channel accepted-datagram counters and a dropped-datagram
//                counter are built. They wrap and are cleared only by rst_n.
//   undefined -> the stat ports remain and are tied to zero.
//
// Parameters
//   NUM_CH     number of output channels (1..8)
//   HDR_BYTES  bytes subtracted from s_udp_length to form m_payload_len
//   CNT_W      width of each statistics counter
//
// Ports
//   logic_clk, rst_n            clock, asynchronous active-low reset
//   s_udp_hdr_*                 input header handshake: source IP, dest port,
//                               and UDP length
//   s_udp_payload_axis_*        input payload byte stream
//   cfg_port / cfg_en           listen port of channel i at [16i+15:16i] and
//                               the per-channel enable; both are sampled only
//                               at header acceptance
//   m_hdr_valid / m_hdr_ready   one-hot output header handshake
//   m_source_ip, m_payload_len  latched header fields, shared by all channels
//   m_axis_*                    payload stream; data/last/user are shared and
//                               tvalid is one-hot
//   drop_pulse                  high during the last byte of a dropped datagram
//   stat_rx_cnt, stat_drop_cnt  statistics counters
// ---------------------------------------------------------------------------
module udp_rx_port_demux #(
    parameter int NUM_CH    = 4,
    parameter int HDR_BYTES = 8,
    parameter int CNT_W     = 32
) (
    input  logic                      logic_clk,
    input  logic                      rst_n,
    input  logic                      s_udp_hdr_valid,
    output logic                      s_udp_hdr_ready,
    input  logic [31:0]               s_udp_ip_source_ip,
    input  logic [15:0]               s_udp_dest_port,
    input  logic [15:0]               s_udp_length,
    input  logic [7:0]                s_udp_payload_axis_tdata,
    input  logic                      s_udp_payload_axis_tvalid,
    output logic                      s_udp_payload_axis_tready,
    input  logic                      s_udp_payload_axis_tlast,
    input  logic                      s_udp_payload_axis_tuser,
    input  logic [16*NUM_CH-1:0]      cfg_port,
    input  logic [NUM_CH-1:0]         cfg_en,
    output logic [NUM_CH-1:0]         m_hdr_valid,
    input  logic [NUM_CH-1:0]         m_hdr_ready,
    output logic [31:0]               m_source_ip,
    output logic [15:0]               m_payload_len,
    output logic [7:0]                m_axis_tdata,
    output logic [NUM_CH-1:0]         m_axis_tvalid,
    input  logic [NUM_CH-1:0]         m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      drop_pulse,
    output logic [CNT_W*NUM_CH-1:0]   stat_rx_cnt,
    output logic [CNT_W-1:0]          stat_drop_cnt
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Port lookup result {found, index}. The scan runs from the top index down,
    // so the lowest matching index is the last one written and wins.
    function automatic logic [SEL_W:0] find_port(
        input logic [16*NUM_CH-1:0] ports,
        input logic [NUM_CH-1:0]    en,
        input logic [15:0]          port
    );
        logic [SEL_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en[i] && (ports[16*i +: 16] == port)) begin
                res = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    // The payload length saturates at zero. A runt length field must not
    // wrap to a huge value.
    function automatic logic [15:0] sat_payload_len(input logic [15:0] len);
        logic [15:0] res;
        if (len < 16'(HDR_BYTES)) begin
            res = 16'd0;
        end else begin
            res = len - 16'(HDR_BYTES);
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [SEL_W-1:0]    sel_r;
    logic [NUM_CH-1:0]   hdr_valid_r;
    logic [31:0]         source_ip_r;
    logic [15:0]         payload_len_r;

    logic [SEL_W:0]      match_s;
    logic                match_found_s;
    logic [SEL_W-1:0]    match_idx_s;
    logic [NUM_CH-1:0]   match_onehot_s;
    logic [NUM_CH-1:0]   sel_onehot_s;
    logic                hdr_hs_s;
    logic                beat_hs_s;
    logic                last_hs_s;

    // Port lookup and one-hot decodes of the lookup result and the latched selection
    always_comb begin
        match_s        = find_port(cfg_port, cfg_en, s_udp_dest_port);
        match_found_s  = match_s[SEL_W];
        match_idx_s    = match_s[SEL_W-1:0];
        match_onehot_s = '0;
        sel_onehot_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match_onehot_s[i] = match_found_s && (match_idx_s == SEL_W'(i));
            sel_onehot_s[i]   = (sel_r == SEL_W'(i));
        end
    end

    // Handshake qualifiers used by the FSM, the datapath registers and the counters
    always_comb begin
        hdr_hs_s  = s_udp_hdr_valid && s_udp_hdr_ready;
        beat_hs_s = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
        last_hs_s = beat_hs_s && s_udp_payload_axis_tlast;
    end

    // FSM state register
    always_ff @(posedge logic_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hdr_hs_s) begin
                    if (match_found_s) begin
                        state_s = ST_HDR;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (m_hdr_ready[sel_r]) begin
                    state_s = ST_PAY;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_PAY, ST_DROP: begin
                if (last_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Header capture, channel selection and the registered one-hot header valid
    always_ff @(posedge logic_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r         <= '0;
            hdr_valid_r   <= '0;
            source_ip_r   <= 32'd0;
            payload_len_r <= 16'd0;
        end else begin
            if ((state_r == ST_IDLE) && hdr_hs_s) begin
                sel_r         <= match_idx_s;
                hdr_valid_r   <= match_onehot_s;
                source_ip_r   <= s_udp_ip_source_ip;
                payload_len_r <= sat_payload_len(s_udp_length);
            end else if ((state_r == ST_HDR) && m_hdr_ready[sel_r]) begin
                hdr_valid_r   <= '0;
            end
        end
    end

    // Handshake and steering outputs. The payload path is zero-latency, so the
    // upstream ready comes straight from the selected channel.
    always_comb begin
        s_udp_hdr_ready           = 1'b0;
        s_udp_payload_axis_tready = 1'b0;
        m_axis_tvalid             = '0;
        drop_pulse                = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_udp_hdr_ready = 1'b1;
            end
            ST_HDR: begin
                s_udp_hdr_ready = 1'b0;
            end
            ST_PAY: begin
                s_udp_payload_axis_tready = m_axis_tready[sel_r];
                m_axis_tvalid = sel_onehot_s & {NUM_CH{s_udp_payload_axis_tvalid}};
            end
            ST_DROP: begin
                s_udp_payload_axis_tready = 1'b1;
                drop_pulse = s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast;
            end
            default: begin
                s_udp_hdr_ready = 1'b0;
            end
        endcase
    end

    // Shared data outputs. They toggle freely because only the valids are qualified.
    always_comb begin
        m_hdr_valid   = hdr_valid_r;
        m_source_ip   = source_ip_r;
        m_payload_len = payload_len_r;
        m_axis_tdata  = s_udp_payload_axis_tdata;
        m_axis_tlast  = s_udp_payload_axis_tlast;
        m_axis_tuser  = s_udp_payload_axis_tuser;
    end

`ifdef UDP_RX_STATS_EN
    logic [NUM_CH-1:0][CNT_W-1:0] rx_cnt_r;
    logic [CNT_W-1:0]             drop_cnt_r;

    // Statistics counters. They count completed datagrams and wrap naturally.
    always_ff @(posedge logic_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_r   <= '0;
            drop_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state_r == ST_PAY) && last_hs_s && sel_onehot_s[i]) begin
                    rx_cnt_r[i] <= rx_cnt_r[i] + CNT_W'(1);
                end
            end
            if (drop_pulse) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stat_rx_cnt   = rx_cnt_r;
    assign stat_drop_cnt = drop_cnt_r;
`else
    assign stat_rx_cnt   = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule
